led_pattern_gen: RTL
====================

// Module: led_pattern_gen
// PURPOSE
//  Parametrised multi-mode LED pattern generator; successor to the fixed-rate binary
//  blink counter. Runtime-loadable tick period, four pattern modes (count, rotate,
//  bounce, hold), registered inverted copy and tick strobe. Sits at board top driving LEDs.
// PARAMETERS
//  WIDTH          8     LED vector width (>=1)
//  CNT_WIDTH      32    prescaler/period register width
//  DEFAULT_PERIOD 1023  period loaded at reset (ticks every DEFAULT_PERIOD+1 cycles)
// PORTS
//  CLK         in   1          clock, all logic on posedge
//  RST         in   1          asynchronous, active-low reset
//  EN          in   1          1: prescaler runs; 0: prescaler, pattern, state frozen
//  MODE        in   2          0 COUNT, 1 ROTATE, 2 BOUNCE, 3 HOLD
//  PERIOD      in   CNT_WIDTH  new period value
//  PERIOD_LOAD in   1          1-cycle strobe: capture PERIOD
//  LED         out  WIDTH      pattern output (registered)
//  INV_LED     out  WIDTH      ~LED delayed one cycle (registered)
//  TICK        out  1          1-cycle pulse, high in the cycle LED takes a new value
// BEHAVIOUR
//  Reset (RST=0, async): count=0, per_reg=DEFAULT_PERIOD, mode_q=0, dir=LEFT,
//   LED=0, INV_LED=0, TICK=0. Reset mid-period discards all progress.
//  Period: PERIOD_LOAD=1 -> per_reg<=PERIOD, count<=0, TICK<=0, no pattern step that
//   cycle (load wins over tick and over EN=0). per_reg=0 -> tick every enabled cycle.
//  Prescaler (EN=1, no load, no mode change): count==per_reg -> count<=0, TICK<=1,
//   LED<=next(LED); else count<=count+1, TICK<=0. EN=0 -> TICK<=0, all else held.
//  Mode change: mode_q registers MODE every cycle. MODE!=mode_q (any EN) -> count<=0,
//   TICK<=0, LED reseeded: COUNT 0, ROTATE 1, BOUNCE 1 with dir=LEFT, HOLD LED unchanged.
//   Change coincident with PERIOD_LOAD: both applied.
//  next(LED) per mode:
//   COUNT  LED+1 mod 2^WIDTH (all-ones wraps to 0)
//   ROTATE {LED[WIDTH-2:0],LED[WIDTH-1]}; if LED==0 reseed to 1
//   BOUNCE FSM dir in {LEFT,RIGHT}, LED one-hot:
//          LEFT : LED<<1; if new LED[WIDTH-1] -> dir<=RIGHT
//          RIGHT: LED>>1; if new LED[0] -> dir<=LEFT
//          LED not one-hot -> reseed 1, dir=LEFT. WIDTH==1: LED stays 1.
//   HOLD   LED unchanged; TICK still pulses
//  INV_LED<=~LED every cycle (incl. EN=0), so INV_LED(t)=~LED(t-1) after reset.
//  Latency: per_reg+1 enabled cycles between TICKs; LED updates on the TICK edge.
// CONFIGURATION
//  LED_PWM_EN defined: extra input BRIGHT[3:0]; free-running 4-bit pwm_cnt (reset 0,
//   counts every cycle regardless of EN); LED port = pattern & {WIDTH{pwm_cnt<BRIGHT}}
//   (registered); BRIGHT=0 -> LED all 0, BRIGHT=15 -> 15/16 duty. INV_LED still
//   uses the ungated pattern. TICK/pattern timing unchanged.
//  LED_PWM_EN undefined: no BRIGHT port, LED = pattern directly.
// TESTING
//  1 Reset release, EN=1, MODE=0, default period -> first TICK and LED=1 at cycle 1024,
//    LED=2 at 2048; INV_LED=8'hFE one cycle after LED=1.
//  2 PERIOD=3 load, MODE=0 from LED=8'hFF -> TICK every 4 cycles, LED wraps 8'hFF->8'h00.
//  3 MODE=2, PERIOD=0, WIDTH=8 -> LED 01,02,..,80,40,..,01,02 each cycle; dir flips at ends.
//  4 MODE 0->1 mid-period with LED=8'h35 -> LED=8'h01, count=0; then 02,04,..,80,01.
//  5 EN=0 for 10 cycles mid-period, then RST=0 pulse async -> LED/TICK frozen, then all
//    outputs 0 immediately, per_reg back to 1023; PERIOD_LOAD and tick same cycle -> no step.
//  6 LED_PWM_EN, BRIGHT=4, pattern 8'hFF -> LED=8'hFF 4 of every 16 cycles; BRIGHT=0 -> 0.

Source files
------------

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-mode LED pattern generator with a runtime-loadable
// tick period. Modes: COUNT, ROTATE, BOUNCE, HOLD. Also provides a registered
// inverted copy of the pattern and a one-cycle TICK strobe on every pattern step.
// Optional feature macro LED_PWM_EN: adds a BRIGHT[3:0] input and gates the LED
// port with a free-running 4-bit PWM comparator (INV_LED stays ungated).
module led_pattern_gen #(
  parameter int          WIDTH          = 8,
  parameter int          CNT_WIDTH      = 32,
  parameter int unsigned DEFAULT_PERIOD = 1023
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [1:0]           MODE,
  input  logic [CNT_WIDTH-1:0] PERIOD,
  input  logic                 PERIOD_LOAD,
`ifdef LED_PWM_EN
  input  logic [3:0]           BRIGHT,
`endif
  output logic [WIDTH-1:0]     LED,
  output logic [WIDTH-1:0]     INV_LED,
  output logic                 TICK
);

  typedef enum logic [1:0] {
    M_COUNT  = 2'd0,
    M_ROTATE = 2'd1,
    M_BOUNCE = 2'd2,
    M_HOLD   = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  logic [WIDTH-1:0]     r_pat;
  logic [WIDTH-1:0]     r_inv;
  logic                 r_tick;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_per;
  mode_t                r_mode;
  dir_t                 r_dir;

  mode_t                w_mode_in;
  logic                 w_mode_chg;
  logic [WIDTH-1:0]     w_step_pat;
  dir_t                 w_step_dir;
  logic [WIDTH-1:0]     w_pat_nxt;
  dir_t                 w_dir_nxt;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic [CNT_WIDTH-1:0] w_per_nxt;
  logic                 w_tick_nxt;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  assign w_mode_in  = mode_t'(MODE);
  assign w_mode_chg = (w_mode_in != r_mode);

  // Pattern that a tick would produce in the currently registered mode.
  always_comb begin
    w_step_pat = r_pat;
    w_step_dir = r_dir;
    case (r_mode)
      M_COUNT: w_step_pat = r_pat + WIDTH'(1);
      M_ROTATE: begin
        if (r_pat == '0) w_step_pat = WIDTH'(1);
        else             w_step_pat = (r_pat << 1) | (r_pat >> (WIDTH - 1));
      end
      M_BOUNCE: begin
        if (WIDTH == 1) begin
          w_step_pat = WIDTH'(1);
          w_step_dir = DIR_LEFT;
        end else if (!is_onehot(r_pat)) begin
          w_step_pat = WIDTH'(1);
          w_step_dir = DIR_LEFT;
        end else if (r_dir == DIR_LEFT) begin
          w_step_pat = r_pat << 1;
          if (w_step_pat[WIDTH-1]) w_step_dir = DIR_RIGHT;
        end else begin
          w_step_pat = r_pat >> 1;
          if (w_step_pat[0]) w_step_dir = DIR_LEFT;
        end
        // A one-hot walked off the end can only come from a stale direction;
        // recover to the canonical start rather than going dark.
        if (w_step_pat == '0) begin
          w_step_pat = WIDTH'(1);
          w_step_dir = DIR_LEFT;
        end
      end
      default: w_step_pat = r_pat;
    endcase
  end

  // Next-state selection: period load and mode change both cancel the step,
  // otherwise the enabled prescaler decides whether this cycle ticks.
  always_comb begin
    w_pat_nxt   = r_pat;
    w_dir_nxt   = r_dir;
    w_count_nxt = r_count;
    w_per_nxt   = r_per;
    w_tick_nxt  = 1'b0;
    if (PERIOD_LOAD) begin
      w_per_nxt   = PERIOD;
      w_count_nxt = '0;
    end
    if (w_mode_chg) begin
      w_count_nxt = '0;
      case (w_mode_in)
        M_COUNT:  w_pat_nxt = '0;
        M_ROTATE: w_pat_nxt = WIDTH'(1);
        M_BOUNCE: begin
          w_pat_nxt = WIDTH'(1);
          w_dir_nxt = DIR_LEFT;
        end
        default:  w_pat_nxt = r_pat;
      endcase
    end else if (!PERIOD_LOAD && EN) begin
      if (r_count == r_per) begin
        w_count_nxt = '0;
        w_tick_nxt  = 1'b1;
        w_pat_nxt   = w_step_pat;
        w_dir_nxt   = w_step_dir;
      end else begin
        w_count_nxt = r_count + CNT_WIDTH'(1);
      end
    end
  end

  // State and registered outputs; INV_LED follows the pattern every cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pat   <= '0;
      r_inv   <= '0;
      r_tick  <= 1'b0;
      r_count <= '0;
      r_per   <= CNT_WIDTH'(DEFAULT_PERIOD);
      r_mode  <= M_COUNT;
      r_dir   <= DIR_LEFT;
    end else begin
      r_pat   <= w_pat_nxt;
      r_inv   <= ~r_pat;
      r_tick  <= w_tick_nxt;
      r_count <= w_count_nxt;
      r_per   <= w_per_nxt;
      r_mode  <= w_mode_in;
      r_dir   <= w_dir_nxt;
    end
  end

`ifdef LED_PWM_EN
  logic [3:0]       r_pwm;
  logic [WIDTH-1:0] r_led;
  logic [3:0]       w_pwm_nxt;

  assign w_pwm_nxt = r_pwm + 4'd1;

  // Free-running brightness counter; the gate uses next-cycle values so the
  // gated LED stays aligned with TICK.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pwm <= 4'd0;
      r_led <= '0;
    end else begin
      r_pwm <= w_pwm_nxt;
      r_led <= w_pat_nxt & {WIDTH{(w_pwm_nxt < BRIGHT)}};
    end
  end

  assign LED = r_led;
`else
  assign LED = r_pat;
`endif

  assign INV_LED = r_inv;
  assign TICK    = r_tick;

endmodule
